module_rr_arbiter_4: RTL

//  Round-robin arbiter and controller for a shared 4:1 data mux (module_mux_4_1).

---
 rtl/module_rr_arbiter_4_pkg.sv | 38 +++
 rtl/module_rr_arbiter_4_mux.sv | 31 +++
 rtl/module_rr_arbiter_4.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/module_rr_arbiter_4_pkg.sv
// ---------------------------------------------------------------------------
// pkg_arb_4
// Shared types and helpers for the 4-way round-robin arbiter.
//   arb_state_t : arbiter FSM state (IDLE waits for a request, BUSY serves one)
//   NUM_REQ     : number of requesters competing for the output bus
//   BEAT_CNT_W  : width of the per-grant beat counter
//   rr_pick()   : round-robin winner search starting after the previous winner
// ---------------------------------------------------------------------------
package pkg_arb_4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int NUM_REQ    = 4;
    localparam int BEAT_CNT_W = 8;

    // Returns the first requester with its request bit set, searching from
    // last+1 upwards with wrap-around 3->0. The previous winner itself is
    // checked last, so it only wins again when nobody else is asking.
    // The loop runs from the farthest candidate to the nearest so that the
    // nearest requesting index is the one left in pick.
    function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                           input logic [1:0]         last);
        logic [1:0] pick;
        logic [1:0] idx;
        pick = last;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/module_rr_arbiter_4_mux.sv
// ---------------------------------------------------------------------------
// module_mux_4_1
// Plain combinational 4:1 word multiplexer for the shared output bus.
// Ports:
//   a_i, b_i, c_i, d_i : input words of requesters 0..3
//   sel_i              : index of the word to forward
//   data_o             : selected word
// ---------------------------------------------------------------------------
module module_mux_4_1 #(
    parameter int BUS_WIDTH = 16
) (
    input  logic [BUS_WIDTH-1:0] a_i,
    input  logic [BUS_WIDTH-1:0] b_i,
    input  logic [BUS_WIDTH-1:0] c_i,
    input  logic [BUS_WIDTH-1:0] d_i,
    input  logic [1:0]           sel_i,
    output logic [BUS_WIDTH-1:0] data_o
);

    always_comb begin
        data_o = a_i;
        case (sel_i)
            2'd0:    data_o = a_i;
            2'd1:    data_o = b_i;
            2'd2:    data_o = c_i;
            2'd3:    data_o = d_i;
            default: data_o = a_i;
        endcase
    end

endmodule

// File: rtl/module_rr_arbiter_4.sv
// ---------------------------------------------------------------------------
// module_rr_arbiter_4
// Round-robin arbiter driving a shared 4:1 data mux. One requester at a time
// owns the bus for a burst of at most MAX_BURST beats; each accepted beat is
// registered into a single-entry valid/ready output stage.
// Ports:
//   clk_i    : clock, all state on the rising edge
//   rst_i    : synchronous active-high reset
//   req_i    : per-requester request (bit 0..3 = a..d)
//   a_i..d_i : requester data words
//   ack_o    : combinational one-hot, beat taken from that requester this cycle
//   gnt_o    : registered one-hot grant, 0 while idle
//   sel_o    : registered mux select (index of the granted requester)
//   data_o   : registered output word
//   valid_o  : data_o holds a word
//   ready_i  : downstream takes data_o when valid_o && ready_i
// ---------------------------------------------------------------------------
module module_rr_arbiter_4 #(
    parameter int BUS_WIDTH = 16,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [3:0]           req_i,
    input  logic [BUS_WIDTH-1:0] a_i,
    input  logic [BUS_WIDTH-1:0] b_i,
    input  logic [BUS_WIDTH-1:0] c_i,
    input  logic [BUS_WIDTH-1:0] d_i,
    output logic [3:0]           ack_o,
    output logic [3:0]           gnt_o,
    output logic [1:0]           sel_o,
    output logic [BUS_WIDTH-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i
);

    import pkg_arb_4::*;

    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(MAX_BURST - 1);

    arb_state_t               state_reg, state_next;
    logic [NUM_REQ-1:0]       gnt_reg, gnt_next;
    logic [1:0]               sel_reg, sel_next;
    logic [1:0]               last_winner_reg, last_winner_next;
    logic [BEAT_CNT_W-1:0]    beat_cnt_reg, beat_cnt_next;
    logic [BUS_WIDTH-1:0]     data_reg, data_next;
    logic                     valid_reg, valid_next;

    logic [NUM_REQ-1:0]       ack;
    logic                     ack_any;
    logic                     slot_free;
    logic                     released;
    logic                     burst_done;
    logic [1:0]               pick;
    logic [BUS_WIDTH-1:0]     mux_data;

    // The mux follows the registered select, so the word captured on an ack
    // always belongs to the requester that currently holds the grant.
    module_mux_4_1 #(
        .BUS_WIDTH(BUS_WIDTH)
    ) u_mux (
        .a_i    (a_i),
        .b_i    (b_i),
        .c_i    (c_i),
        .d_i    (d_i),
        .sel_i  (sel_reg),
        .data_o (mux_data)
    );

    // The output stage can take a new word when it is empty or when its
    // current word leaves in this same cycle.
    assign slot_free = !valid_reg || ready_i;

    // Only the granted requester can be acked, and only while it still
    // requests; a requester dropping req_i is never acked in that cycle.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ack
            assign ack[gi] = (state_reg == BUSY) && gnt_reg[gi] &&
                             req_i[gi] && slot_free;
        end
    endgenerate

    assign ack_any    = |ack;
    assign released   = !req_i[sel_reg];
    assign burst_done = ack_any && (beat_cnt_reg == LAST_BEAT);
    assign pick       = rr_pick(req_i, last_winner_reg);

    always_comb begin
        state_next       = state_reg;
        gnt_next         = gnt_reg;
        sel_next         = sel_reg;
        last_winner_next = last_winner_reg;
        beat_cnt_next    = beat_cnt_reg;
        data_next        = data_reg;
        valid_next       = valid_reg;

        case (state_reg)
            IDLE: begin
                if (|req_i) begin
                    state_next       = BUSY;
                    gnt_next         = NUM_REQ'(1) << pick;
                    sel_next         = pick;
                    last_winner_next = pick;
                end
            end
            BUSY: begin
                // Under backpressure ack is low, so the counter simply holds
                // and the burst is never timed out.
                if (ack_any) begin
                    beat_cnt_next = beat_cnt_reg + 1'b1;
                end
                // Dropping the grant here costs one idle cycle before the
                // next winner is registered, which is the arbitration slot.
                if (released || burst_done) begin
                    state_next    = IDLE;
                    gnt_next      = '0;
                    beat_cnt_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
        endcase

        // Output stage runs independently of the FSM so that a word
        // captured on the final beat still drains while the arbiter idles.
        if (ack_any) begin
            data_next  = mux_data;
            valid_next = 1'b1;
        end else if (valid_reg && ready_i) begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg       <= IDLE;
            gnt_reg         <= '0;
            sel_reg         <= 2'd0;
            last_winner_reg <= 2'd3;
            beat_cnt_reg    <= '0;
            data_reg        <= '0;
            valid_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            gnt_reg         <= gnt_next;
            sel_reg         <= sel_next;
            last_winner_reg <= last_winner_next;
            beat_cnt_reg    <= beat_cnt_next;
            data_reg        <= data_next;
            valid_reg       <= valid_next;
        end
    end

    assign ack_o   = ack;
    assign gnt_o   = gnt_reg;
    assign sel_o   = sel_reg;
    assign data_o  = data_reg;
    assign valid_o = valid_reg;

endmodule
